fp_mul_driver: RTL and testbench
================================

FP_MUL_DRIVER -- requirements
Module: fp_mul_driver

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; asserting it (low) immediately forces the reset state.
REQ-003 start  input  1  request pulse; sampled on a rising edge only while idle.
REQ-004 a_bits  input  32  IEEE-754 binary32 operand A; captured on the accepting edge.
REQ-005 b_bits  input  32  IEEE-754 binary32 operand B; captured on the accepting edge.
REQ-006 busy  output  1  high while an operation is in flight.
REQ-007 done  output  1  one-cycle pulse marking z_bits valid.
REQ-008 z_bits  output  32  binary32 product A*B; registered.

Function
REQ-009 States SHALL be IDLE, MUL, NORM, ROUND.
- IDLE->MUL on start=1.
- MUL runs 13 cycles, then NORM (1 cycle), then ROUND (1 cycle), then IDLE.
REQ-010 Acceptance: start=1 in IDLE at edge T0 SHALL latch both operands, enter MUL, and set busy=1 from T0.
REQ-011 start SHALL be ignored while busy=1; it has no queueing effect.
REQ-012 Timing at edge T0+15:
- z_bits SHALL update.
- done SHALL be 1 for exactly that cycle.
- busy SHALL be 0 from that edge.
- A new start SHALL be accepted on the following edge.
REQ-013 z_bits SHALL hold its value until the next done.
REQ-014 Sign SHALL equal a[31] XOR b[31] for all results, including zero and infinity.
REQ-015 Mantissa product:
- Form the 24x24 significand product (hidden 1 restored) with radix-4 Booth recoding, 13 digits, one per MUL cycle.
- Accumulate in carry-save form using a 3:2 CSA.
- Resolve with a single carry-propagate add in NORM.
- The result is exact 48 bits.
REQ-016 Exponent SHALL be ea+eb-127, computed with at least 10 signed bits, plus 1 if product bit 47 is set (normalization right-shift by 1).
REQ-017 Rounding SHALL be round-to-nearest-even using guard, round and sticky (OR of all lower bits). A mantissa carry-out after rounding SHALL renormalize and increment the exponent.
REQ-018 Overflow: final exponent >= 255 SHALL produce signed infinity.
REQ-019 Underflow: final exponent <= 0 SHALL flush to signed zero (no subnormal output).
REQ-020 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero.
REQ-021 Special operands SHALL bypass the datapath but keep the same 15-cycle latency:
- Any NaN input, or Inf*0: 0x7FC00000.
- Inf*finite-nonzero or Inf*Inf: signed infinity.
- Zero*finite: signed zero.

Reset
REQ-022 While rst=0:
- State SHALL be IDLE.
- busy=0, done=0, z_bits=0x00000000.
- Internal accumulators SHALL be cleared.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse. Operation after deassertion SHALL start from IDLE.

Structure
REQ-024 Package fp_mul_pkg SHALL hold:
- Constants: EXP_BIAS=127, EXP_W=8, FRAC_W=23, QNAN=32'h7FC00000, MUL_CYCLES=13.
- The state enum typedef.
REQ-025 Booth digit selection plus CSA accumulation SHALL be one sub-module, fp_mul_booth_csa, with a step enable, a clear, and carry-save sum/carry outputs.
REQ-026 Control FSM, unpack/special detection, normalize, round and pack SHALL reside in fp_mul_driver.

Verification
REQ-027 0x3F800000 * 0x3F800000 -> z_bits=0x3F800000, with done 15 cycles after start.
REQ-028 0x40000000 * 0x3F000000 -> 0x3F800000.
REQ-029 0xBFC00000 * 0x40000000 -> 0xC0400000.
REQ-030 0x40833333 * 0xC04CCCCD -> 0xC151EB85 (RNE rounding).
REQ-031 Special and boundary values:
- 0x7F800000 * 0x00000000 -> 0x7FC00000.
- 0x7F000000 * 0x40000000 -> 0x7F800000.
- 0x00800000 * 0x00800000 -> 0x00000000.
REQ-032 Protocol checks:
- start pulsed while busy is ignored.
- rst low mid-operation clears busy/done/z_bits, and no done follows.
- Back-to-back operations each yield exactly one done.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants, state type and operand helpers for the binary32 multiplier
package fp_mul_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int MUL_CYCLES = 13;
    // 48-bit product plus headroom so negative Booth digits wrap harmlessly
    localparam int ACC_W      = 50;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_ROUND
    } state_t;

    // Subnormals count as zero, so the hidden bit is set only for a nonzero exponent.
    function automatic logic [FRAC_W:0] signif(input logic [31:0] x);
        return {(x[30:23] != '0), x[22:0]};
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == '0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == '1) && (x[22:0] == '0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == '1) && (x[22:0] != '0);
    endfunction

endpackage

// File: rtl/fp_mul_booth_csa.sv
// rtl/fp_mul_booth_csa.sv - one radix-4 Booth digit per step, accumulated in carry-save form
module fp_mul_booth_csa
    import fp_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [3:0]       i_idx,
    input  logic [23:0]      i_mcand,
    input  logic [23:0]      i_mplier,
    output logic [ACC_W-1:0] o_sum,
    output logic [ACC_W-1:0] o_carry
);

    logic [ACC_W-1:0] r_sum, r_carry;
    logic [26:0]      w_ext;
    logic [2:0]       w_trip;
    logic             w_neg, w_dbl, w_nz;
    logic [ACC_W-1:0] w_mag, w_pp, w_sum_n;
    logic [ACC_W-2:0] w_maj;

    assign w_ext  = {2'b00, i_mplier, 1'b0};
    assign w_trip = 3'(w_ext >> {i_idx, 1'b0});

    always_comb begin
        w_nz  = 1'b1;
        w_neg = 1'b0;
        w_dbl = 1'b0;
        case (w_trip)
            3'b001, 3'b010: ;
            3'b011:         w_dbl = 1'b1;
            3'b100:         begin w_dbl = 1'b1; w_neg = 1'b1; end
            3'b101, 3'b110: w_neg = 1'b1;
            default:        w_nz  = 1'b0;
        endcase
    end

    assign w_mag = ({{(ACC_W-24){1'b0}}, i_mcand} << w_dbl) << {i_idx, 1'b0};
    // Negative digits use ones' complement here; the +1 rides in the free carry LSB.
    assign w_pp    = !w_nz ? '0 : (w_neg ? ~w_mag : w_mag);
    assign w_sum_n = r_sum ^ r_carry ^ w_pp;
    assign w_maj   = (r_sum[ACC_W-2:0] & r_carry[ACC_W-2:0])
                   | (r_sum[ACC_W-2:0] & w_pp[ACC_W-2:0])
                   | (r_carry[ACC_W-2:0] & w_pp[ACC_W-2:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum   <= '0;
            r_carry <= '0;
        end else if (i_clear) begin
            r_sum   <= '0;
            r_carry <= '0;
        end else if (i_step) begin
            r_sum   <= w_sum_n;
            r_carry <= {w_maj, w_neg & w_nz};
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule

// File: rtl/fp_mul_driver.sv
// rtl/fp_mul_driver.sv - multi-cycle binary32 multiplier: control, specials, normalize, round, pack
module fp_mul_driver
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_bits,
    input  logic [31:0] b_bits,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_bits
);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_a, r_b, r_z;
    logic [47:0]        r_prod;
    logic signed [9:0]  r_exp;
    logic               r_busy, r_done;

    logic [ACC_W-1:0]   w_sum, w_carry;
    logic [47:0]        w_full;
    logic [9:0]         w_exp_n;
    logic [46:0]        w_norm;
    logic               w_sign, w_guard, w_round, w_sticky, w_rup;
    logic [23:0]        w_rnd;
    logic signed [9:0]  w_exp_f;
    logic [31:0]        w_result;

    fp_mul_booth_csa u_booth (
        .clk      (clk),
        .rst      (rst),
        .i_clear  ((r_state == ST_IDLE) && start),
        .i_step   (r_state == ST_MUL),
        .i_idx    (r_cnt),
        .i_mcand  (signif(r_a)),
        .i_mplier (signif(r_b)),
        .o_sum    (w_sum),
        .o_carry  (w_carry)
    );

    assign w_full  = 48'(w_sum + w_carry);
    assign w_exp_n = {2'b00, r_a[30:23]} + {2'b00, r_b[30:23]} - 10'(EXP_BIAS) + {9'd0, w_full[47]};

    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_norm   = r_prod[47] ? r_prod[46:0] : {r_prod[45:0], 1'b0};
    assign w_guard  = w_norm[23];
    assign w_round  = w_norm[22];
    assign w_sticky = |w_norm[21:0];
    assign w_rup    = w_guard & (w_round | w_sticky | w_norm[24]);
    assign w_rnd    = {1'b0, w_norm[46:24]} + {23'd0, w_rup};
    // A rounding carry leaves the fraction at zero, so only the exponent moves.
    assign w_exp_f  = r_exp + $signed({9'd0, w_rnd[23]});

    always_comb begin
        w_result = {w_sign, w_exp_f[7:0], w_rnd[22:0]};
        if (is_nan(r_a) || is_nan(r_b) || (is_inf(r_a) && is_zero(r_b)) || (is_inf(r_b) && is_zero(r_a)))
            w_result = QNAN;
        else if (is_inf(r_a) || is_inf(r_b))
            w_result = {w_sign, 8'hFF, 23'd0};
        else if (is_zero(r_a) || is_zero(r_b))
            w_result = {w_sign, 31'd0};
        else if (w_exp_f >= 10'sd255)
            w_result = {w_sign, 8'hFF, 23'd0};
        else if (w_exp_f <= 10'sd0)
            w_result = {w_sign, 31'd0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_z     <= '0;
            r_prod  <= '0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a     <= a_bits;
                    r_b     <= b_bits;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(MUL_CYCLES - 1))
                        r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_prod  <= w_full;
                    r_exp   <= $signed(w_exp_n);
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_z     <= w_result;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign z_bits = r_z;

endmodule

// File: tb/tb_fp_mul_driver.sv
// tb/tb_fp_mul_driver.sv - scoreboard bench for fp_mul_driver with directed binary32 vectors
module tb_fp_mul_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_bits = '0;
    logic [31:0] b_bits = '0;
    logic        busy, done;
    logic [31:0] z_bits;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [31:0] last_z = '0;

    typedef struct {
        logic [31:0] z;
        int          at;
        int          id;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;
    vec_t vecs[15] = '{
        '{32'h3F800000, 32'h3F800000, 32'h3F800000},
        '{32'h40000000, 32'h3F000000, 32'h3F800000},
        '{32'hBFC00000, 32'h40000000, 32'hC0400000},
        '{32'h40833333, 32'hC04CCCCD, 32'hC151EB85},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000},
        '{32'h7F000000, 32'h40000000, 32'h7F800000},
        '{32'h00800000, 32'h00800000, 32'h00000000},
        '{32'h40400000, 32'h40400000, 32'h41100000},
        '{32'h80000000, 32'h3F800000, 32'h80000000},
        '{32'hFF800000, 32'h7F800000, 32'hFF800000},
        '{32'h7F800001, 32'h3F800000, 32'h7FC00000},
        '{32'h00000001, 32'hC0000000, 32'h80000000},
        '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE},
        '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000},
        '{32'h3F7FFFFF, 32'h3F800001, 32'h3F800000}
    };

    fp_mul_driver dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_bits (a_bits),
        .b_bits (b_bits),
        .busy   (busy),
        .done   (done),
        .z_bits (z_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks value, latency and busy.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: actual done=1 at cycle %0d required no done", cyc);
            end else begin
                e = sbq.pop_front();
                check($sformatf("op%0d_z", e.id), z_bits, e.z);
                check($sformatf("op%0d_latency", e.id), cyc, e.at);
                check($sformatf("op%0d_busy_at_done", e.id), {31'd0, busy}, 32'd0);
            end
        end else if (rst) begin
            check("z_hold", z_bits, last_z);
        end
        last_z = z_bits;
    end

    // Call right after a negedge; start is seen by the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ez,
                         input int id, input bit expect_it);
        exp_t e;
        start  = 1'b1;
        a_bits = a;
        b_bits = b;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("op%0d_busy_after_start", id), {31'd0, busy}, 32'd1);
        if (expect_it) begin
            e.z  = ez;
            e.at = cyc + 15;
            e.id = id;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: actual %0d results pending required 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: actual done=0 required done within 40 cycles");
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_z", z_bits, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].z, i, 1'b1);
            wait_idle();
        end

        // Back-to-back: each new start lands on the edge right after done.
        issue(32'h40000000, 32'h40000000, 32'h40800000, 100, 1'b1);
        wait_done();
        issue(32'hC0400000, 32'h40400000, 32'hC1100000, 101, 1'b1);
        wait_done();
        issue(32'h3F000000, 32'h3F000000, 32'h3E800000, 102, 1'b1);
        wait_idle();
        repeat (20) @(negedge clk);

        // A start while busy must not produce a second result.
        issue(32'h40400000, 32'h40000000, 32'h40C00000, 200, 1'b1);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        a_bits = 32'h41000000;
        b_bits = 32'h41000000;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (25) @(negedge clk);

        // Reset mid-operation aborts it with no done.
        issue(32'h40A00000, 32'h40A00000, 32'h41C80000, 300, 1'b0);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_z", z_bits, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (25) @(negedge clk);

        issue(32'h40A00000, 32'h40A00000, 32'h41C80000, 301, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
